inst_fetch_responder: RTL

Instruction-side responder for the dual-issue fetch stage. It takes the fetch PC, which addresses a pair of sequential words (slot 1 at `fetch_pc`, slot 2 at `fetch_pc+4`), and runs two reads on an SRAM-like instruction bus. It returns both words to IF, holds the pipeline through `delay_hard` while the pair is not ready, and raises the address-error / address-fault flags that IF forwards as `IADEE`/`IADFE`.

---
 rtl/inst_fetch_responder_if.sv | 33 +++
 rtl/inst_fetch_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_responder_if.sv
// Instruction-bus interface between the fetch responder and the SRAM-like
// instruction memory. Read-only, one outstanding request at a time.
//   inst_req      request, held until inst_addr_ok
//   inst_addr     physical address, stable while inst_req is waiting
//   inst_addr_ok  address accepted this cycle
//   inst_data_ok  read data valid this cycle
//   inst_rdata    read data
// master: the fetch responder; slave: the memory side.
interface inst_fetch_responder_if;
  localparam int unsigned XLEN = 32;

  logic            inst_req;
  logic [XLEN-1:0] inst_addr;
  logic            inst_addr_ok;
  logic            inst_data_ok;
  logic [XLEN-1:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/inst_fetch_responder.sv
// Instruction-side responder for the dual-issue fetch stage.
// Fetches the word pair {fetch_pc, fetch_pc+4} over the instruction bus with
// two sequential reads, returns both words to IF and stalls IF (delay_hard)
// until the pair held for the current fetch_pc is complete.
// Ports:
//   clk, reset    clock; asynchronous active-low reset
//   fetch_pc      virtual address of the slot-1 instruction
//   flush         redirect/interrupt, abandons the pair in flight
//   if_inst_1/2   slot-1/slot-2 instruction, valid while delay_hard==0
//   delay_hard    combinational stall to IF
//   IADEE         fetch_pc misaligned
//   IADFE/IADFE_2 slot-1/slot-2 address outside kseg0/kseg1
//   bus           instruction bus (master side)
module inst_fetch_responder #(
  parameter logic [31:0] KSEG_MASK = 32'h1FFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic [31:0] if_inst_1,
  output logic [31:0] if_inst_2,
  output logic        delay_hard,
  output logic        IADEE,
  output logic        IADFE,
  output logic        IADFE_2,
  inst_fetch_responder_if.master bus
);

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ1  = 3'd1;
  localparam logic [2:0] S_WAIT1 = 3'd2;
  localparam logic [2:0] S_REQ2  = 3'd3;
  localparam logic [2:0] S_WAIT2 = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  // kseg0/kseg1 occupy the 2'b10 segment of the virtual space
  function automatic logic is_mapped(input logic [1:0] seg);
    return seg == 2'b10;
  endfunction

  function automatic logic [XLEN-1:0] phys(input logic [XLEN-1:0] va);
    return va & KSEG_MASK;
  endfunction

  logic [2:0]      state, state_nxt;
  logic [XLEN-1:0] cur_pc, cur_pc_nxt;
  logic            valid, valid_nxt;
  logic            abort, abort_nxt;
  logic [XLEN-1:0] inst1_nxt, inst2_nxt;
  logic            iadee_nxt, iadfe_nxt, iadfe2_nxt;
  logic            req_nxt;
  logic [XLEN-1:0] addr_nxt;

  logic [XLEN-1:0] fetch_pc2;
  logic [XLEN-1:0] cur_pc2;
  logic            hit;
  logic            take_data;
  logic            pc_misaligned;
  logic            pc_err;

  assign fetch_pc2     = fetch_pc + XLEN'(4);
  assign cur_pc2       = cur_pc + XLEN'(4);
  assign hit           = valid && (fetch_pc == cur_pc) && (state == S_IDLE);
  assign delay_hard    = !hit;
  // read data is only captured for a live (non-aborted) pair
  assign take_data     = bus.inst_data_ok && !abort;
  assign pc_misaligned = |fetch_pc[1:0];
  assign pc_err        = pc_misaligned || !is_mapped(fetch_pc[31:30]);

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    cur_pc_nxt = cur_pc;
    valid_nxt  = valid;
    abort_nxt  = abort;
    inst1_nxt  = if_inst_1;
    inst2_nxt  = if_inst_2;
    iadee_nxt  = IADEE;
    iadfe_nxt  = IADFE;
    iadfe2_nxt = IADFE_2;
    req_nxt    = 1'b0;
    addr_nxt   = bus.inst_addr;

    case (state)
      S_IDLE: begin
        if (flush) begin
          valid_nxt = 1'b0;
        end else if (!hit) begin
          cur_pc_nxt = fetch_pc;
          if (pc_err) begin
            // error pair completes locally without touching the bus
            inst1_nxt  = '0;
            inst2_nxt  = '0;
            iadee_nxt  = pc_misaligned;
            iadfe_nxt  = !is_mapped(fetch_pc[31:30]);
            iadfe2_nxt = !is_mapped(fetch_pc2[31:30]);
            valid_nxt  = 1'b1;
          end else begin
            // old pair is no longer what cur_pc points at
            valid_nxt  = 1'b0;
            iadee_nxt  = 1'b0;
            iadfe_nxt  = 1'b0;
            iadfe2_nxt = 1'b0;
            req_nxt    = 1'b1;
            addr_nxt   = phys(fetch_pc);
            state_nxt  = S_REQ1;
          end
        end
      end

      S_REQ1, S_REQ2: begin
        if (flush) begin
          if (bus.inst_addr_ok) begin
            // address already accepted: its data must still be drained
            abort_nxt = 1'b1;
            state_nxt = S_DRAIN;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (bus.inst_addr_ok) begin
          state_nxt = (state == S_REQ1) ? S_WAIT1 : S_WAIT2;
        end else begin
          req_nxt = 1'b1;
        end
      end

      S_WAIT1: begin
        if (flush) begin
          if (bus.inst_data_ok) begin
            state_nxt = S_IDLE;
          end else begin
            abort_nxt = 1'b1;
            state_nxt = S_DRAIN;
          end
        end else if (take_data) begin
          inst1_nxt = bus.inst_rdata;
          if (!is_mapped(cur_pc2[31:30])) begin
            inst2_nxt  = '0;
            iadfe2_nxt = 1'b1;
            valid_nxt  = 1'b1;
            state_nxt  = S_IDLE;
          end else begin
            req_nxt   = 1'b1;
            addr_nxt  = phys(cur_pc2);
            state_nxt = S_REQ2;
          end
        end
      end

      S_WAIT2: begin
        if (flush) begin
          if (bus.inst_data_ok) begin
            state_nxt = S_IDLE;
          end else begin
            abort_nxt = 1'b1;
            state_nxt = S_DRAIN;
          end
        end else if (take_data) begin
          inst2_nxt = bus.inst_rdata;
          valid_nxt = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (bus.inst_data_ok) begin
          abort_nxt = 1'b0;
          valid_nxt = 1'b0;
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cur_pc        <= '0;
      valid         <= 1'b0;
      abort         <= 1'b0;
      if_inst_1     <= '0;
      if_inst_2     <= '0;
      IADEE         <= 1'b0;
      IADFE         <= 1'b0;
      IADFE_2       <= 1'b0;
      bus.inst_req  <= 1'b0;
      bus.inst_addr <= '0;
    end else begin
      state         <= state_nxt;
      cur_pc        <= cur_pc_nxt;
      valid         <= valid_nxt;
      abort         <= abort_nxt;
      if_inst_1     <= inst1_nxt;
      if_inst_2     <= inst2_nxt;
      IADEE         <= iadee_nxt;
      IADFE         <= iadfe_nxt;
      IADFE_2       <= iadfe2_nxt;
      bus.inst_req  <= req_nxt;
      bus.inst_addr <= addr_nxt;
    end
  end

endmodule
